// File: rtl/math_expr_arbiter.sv
// rtl/math_expr_arbiter.sv - round-robin arbiter sharing one math_expression datapath among N requesters
module math_expr_arbiter #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int TMO = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N*W-1:0] req_c,
    input  logic [N*W-1:0] req_d,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_q,
    output logic           rsp_rmd,
    output logic           rsp_err,
    output logic           busy,
    output logic           dp_start,
    output logic [W-1:0]   dp_a,
    output logic [W-1:0]   dp_b,
    output logic [W-1:0]   dp_c,
    output logic [W-1:0]   dp_d,
    input  logic [W-1:0]   dp_q,
    input  logic           dp_rmd,
    input  logic           dp_valid
);

    localparam int IW  = $clog2(N);
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(TMO);
    localparam logic [IW:0]   N_L      = IW1'(N);
    localparam logic [IW-1:0] LAST_ID  = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
    localparam logic [N-1:0]  ONE      = N'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, id, win_id;
    logic [IW:0]   idx;
    logic          win_found;
    logic [CW-1:0] cnt;
    logic [N-1:0]  id_oh;

    // Scan from ptr upward, wrapping at N; the first asserted request wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + IW1'(k);
            if (idx >= N_L) idx = idx - N_L;
            if (!win_found && req[idx[IW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IW-1:0];
            end
        end
    end

    assign id_oh = ONE << id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        dp_start  = 1'b0;
        gnt       = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_found) state_nx = ISSUE;
            end
            ISSUE: begin
                dp_start = 1'b1;
                gnt      = id_oh;
                state_nx = WAIT;
            end
            WAIT: begin
                if (dp_valid || cnt == CNT_LAST) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = id_oh;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            id      <= '0;
            cnt     <= '0;
            dp_a    <= '0;
            dp_b    <= '0;
            dp_c    <= '0;
            dp_d    <= '0;
            rsp_q   <= '0;
            rsp_rmd <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        id   <= win_id;
                        dp_a <= req_a[win_id*W +: W];
                        dp_b <= req_b[win_id*W +: W];
                        dp_c <= req_c[win_id*W +: W];
                        dp_d <= req_d[win_id*W +: W];
                    end
                end
                ISSUE: begin
                    ptr <= (id == LAST_ID) ? '0 : id + 1'b1;
                    cnt <= '0;
                end
                WAIT: begin
                    if (dp_valid) begin
                        rsp_q   <= dp_q;
                        rsp_rmd <= dp_rmd;
                        rsp_err <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        // Watchdog expiry: report an error with a zeroed result.
                        rsp_q   <= '0;
                        rsp_rmd <= 1'b0;
                        rsp_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_math_expr_arbiter.sv
// tb/tb_math_expr_arbiter.sv - directed scoreboard bench for math_expr_arbiter
module tb_math_expr_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int TMO = 8;

    typedef struct packed {
        logic [N-1:0] oh;
        logic [W-1:0] q;
        logic         rmd;
        logic         err;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_q;
    logic           rsp_rmd, rsp_err, busy, dp_start;
    logic [W-1:0]   dp_a, dp_b, dp_c, dp_d, dp_q;
    logic           dp_rmd, dp_valid;

    logic           dpm_valid = 1'b0;
    logic [W-1:0]   dpm_q = '0;
    logic           dpm_rmd = 1'b0;
    logic           spur = 1'b0;
    logic           suppress = 1'b0;

    math_expr_arbiter #(.W(W), .N(N), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_rmd(rsp_rmd),
        .rsp_err(rsp_err), .busy(busy), .dp_start(dp_start),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_q(dp_q), .dp_rmd(dp_rmd), .dp_valid(dp_valid)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: n = a - b + 16*c*d, q = n >>> 1, rmd = n[0], one cycle after start.
    function automatic logic [W:0] model(input logic signed [W-1:0] a, b, c, d);
        logic signed [W-1:0] n;
        n = a - b + 16 * c * d;
        return {n >>> 1, n[0]};
    endfunction

    always @(posedge clk) begin
        dpm_valid <= dp_start & ~suppress;
        if (dp_start) {dpm_q, dpm_rmd} <= model(dp_a, dp_b, dp_c, dp_d);
    end

    assign dp_valid = dpm_valid | spur;
    assign dp_q     = dpm_q;
    assign dp_rmd   = dpm_rmd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        sb_t e;
        @(negedge clk);
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_rsp_valid", 64'(rsp_valid), 64'(e.oh));
                chk("sb_rsp_q", 64'(rsp_q), 64'(e.q));
                chk("sb_rsp_rmd", 64'(rsp_rmd), 64'(e.rmd));
                chk("sb_rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    endtask

    task automatic set_ops(input int r, input logic [W-1:0] a, b, c, d);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_c[r*W +: W] = c;
        req_d[r*W +: W] = d;
    endtask

    task automatic push(input int r, input logic [W-1:0] q, input logic rmd, input logic err);
        sb_t e;
        e.oh  = '0;
        e.oh[r] = 1'b1;
        e.q   = q;
        e.rmd = rmd;
        e.err = err;
        sb.push_back(e);
    endtask

    // Called at a negedge with the arbiter idle; that cycle is cycle 0.
    task automatic run_one(input int r, input logic [W-1:0] a, b, c, d,
                           input logic [W-1:0] eq, input logic er);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        set_ops(r, a, b, c, d);
        push(r, eq, er, 1'b0);
        req = oh;
        nxt();
        chk("gnt_cycle1", 64'(gnt), 64'(oh));
        chk("dp_start_cycle1", 64'(dp_start), 64'd1);
        req = '0;
        nxt();
        chk("no_rsp_cycle2", 64'(rsp_valid), 64'd0);
        nxt();
        chk("rsp_cycle3", 64'(rsp_valid), 64'(oh));
        nxt();
        chk("idle_after_rsp", 64'(busy), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] oa[N], ob[N], oc[N], od[N];
        logic [W:0]   m;
        logic [N-1:0] ohx;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dp_start", 64'(dp_start), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_q", 64'(rsp_q), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_dp_a", 64'(dp_a), 64'd0);
        reset = 1'b0;
        nxt();
        chk("idle_after_reset", 64'(busy), 64'd0);

        run_one(0, 10, 4, 2, 1, 19, 1'b0);
        chk("q_hold", 64'(rsp_q), 64'd19);
        run_one(2, 5, 2, 0, 0, 1, 1'b1);
        run_one(3, 0, 1, 0, 0, 32'hFFFF_FFFF, 1'b1);

        // Round robin with every request held high.
        for (int i = 0; i < N; i++) begin
            oa[i] = W'($urandom_range(0, 5000));
            ob[i] = W'($urandom_range(0, 5000));
            oc[i] = W'($urandom_range(0, 20));
            od[i] = W'($urandom_range(0, 20));
            set_ops(i, oa[i], ob[i], oc[i], od[i]);
        end
        for (int k = 0; k < 5; k++) begin
            m = model(oa[k % N], ob[k % N], oc[k % N], od[k % N]);
            push(k % N, m[W:1], m[0], 1'b0);
        end
        req = '1;
        for (int k = 0; k < 5; k++) begin
            ohx = '0;
            ohx[k % N] = 1'b1;
            nxt();
            chk("rr_gnt", 64'(gnt), 64'(ohx));
            if (k == 4) req = '0;
            nxt();
            chk("rr_gap", 64'(gnt), 64'd0);
            nxt();
            nxt();
        end
        chk("rr_idle", 64'(busy), 64'd0);

        // Watchdog timeout.
        suppress = 1'b1;
        set_ops(1, 3, 1, 0, 0);
        push(1, '0, 1'b0, 1'b1);
        req = 4'b0010;
        nxt();
        chk("tmo_gnt", 64'(gnt), 64'b0010);
        req = '0;
        for (int c = 2; c <= TMO + 1; c++) begin
            nxt();
            chk("tmo_wait", 64'(rsp_valid), 64'd0);
        end
        nxt();
        chk("tmo_rsp", 64'(rsp_valid), 64'b0010);
        chk("tmo_err", 64'(rsp_err), 64'd1);
        suppress = 1'b0;
        nxt();
        run_one(2, 7, 3, 1, 2, 18, 1'b0);
        chk("post_tmo_err", 64'(rsp_err), 64'd0);

        // Reset during WAIT.
        set_ops(1, 8, 2, 0, 0);
        req = 4'b0010;
        nxt();
        chk("rst_mid_gnt", 64'(gnt), 64'b0010);
        req = '0;
        nxt();
        chk("rst_mid_in_wait", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_dp_start", 64'(dp_start), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_rsp_q", 64'(rsp_q), 64'd0);
        chk("rst_mid_dp_a", 64'(dp_a), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nxt();
        nxt();
        set_ops(0, 10, 4, 2, 1);
        set_ops(2, 5, 2, 0, 0);
        push(0, 19, 1'b0, 1'b0);
        req = 4'b0101;
        nxt();
        chk("rst_ptr_gnt", 64'(gnt), 64'b0001);
        req = '0;
        nxt();
        nxt();
        chk("rst_ptr_rsp", 64'(rsp_valid), 64'b0001);
        nxt();

        // Spurious dp_valid in IDLE and in RESP.
        spur = 1'b1;
        nxt();
        spur = 1'b0;
        chk("spur_idle_busy", 64'(busy), 64'd0);
        chk("spur_idle_q", 64'(rsp_q), 64'd19);
        set_ops(3, 9, 4, 0, 0);
        push(3, 2, 1'b1, 1'b0);
        req = 4'b1000;
        nxt();
        chk("spur_gnt", 64'(gnt), 64'b1000);
        req = '0;
        nxt();
        nxt();
        chk("spur_rsp", 64'(rsp_valid), 64'b1000);
        spur = 1'b1;
        nxt();
        spur = 1'b0;
        chk("spur_resp_busy", 64'(busy), 64'd0);
        chk("spur_resp_q", 64'(rsp_q), 64'd2);
        nxt();
        chk("spur_resp_still_idle", 64'(busy), 64'd0);
        run_one(0, 1, 6, 1, 1, 5, 1'b1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/math_expr_arbiter.md
# math_expr_arbiter

Round-robin arbiter and sequencer that shares one `math_expression` datapath among N requesters. It accepts operand sets (a, b, c, d) from requesters and issues them one at a time to the datapath as a single-cycle `start`. It captures the one-cycle `valid`/`q`/`rmd` result and routes it back to the originating requester with a one-cycle response pulse. A watchdog terminates any operation whose datapath result never arrives.

## Interface
- `W`, 32, operand/result width; must match the datapath `W`.
- `N`, 4, number of requesters (2..16).
- `TMO`, 8, watchdog limit in WAIT cycles (≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N  request bit per requester; sampled only in IDLE.
- `req_a`, `req_b`, `req_c`, `req_d`  in  N*W each  signed operands; requester i at bits [i*W +: W].
- `gnt`  out  N  one-hot, one-cycle pulse: operands of that requester accepted.
- `rsp_valid`  out  N  one-hot, one-cycle pulse: response for that requester.
- `rsp_q`  out  W  signed quotient for the current response.
- `rsp_rmd`  out  1  remainder bit for the current response.
- `rsp_err`  out  1  high with `rsp_valid` when the operation timed out.
- `busy`  out  1  high in every state except IDLE.
- `dp_start`  out  1  start to the datapath.
- `dp_a`, `dp_b`, `dp_c`, `dp_d`  out  W each  operands to the datapath.
- `dp_q`  in  W  datapath quotient.
- `dp_rmd`  in  1  datapath remainder bit.
- `dp_valid`  in  1  datapath done tick.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** If `req` is nonzero, select the winner by scanning from `ptr` upward modulo N; the first set bit wins. Latch winner id and its four operands, then go to ISSUE. Otherwise stay.
- **ISSUE (exactly 1 cycle):**
  - `dp_start`=1 and `gnt[id]`=1.
  - `dp_a`..`dp_d` show the latched operands; they hold these values until the next selection.
  - `ptr` <= (id+1) mod N.
  - Clear the watchdog counter and go to WAIT.
- **WAIT:**
  - If `dp_valid`=1, capture `dp_q`→`rsp_q` and `dp_rmd`→`rsp_rmd`, set `rsp_err`=0, and go to RESP.
  - Else if the counter equals TMO-1, set `rsp_q`=0, `rsp_rmd`=0, `rsp_err`=1, and go to RESP.
  - Else increment the counter.
- **RESP (exactly 1 cycle):** `rsp_valid[id]`=1, then go to IDLE.
  - `rsp_q`, `rsp_rmd` and `rsp_err` hold until the next capture.
- All outputs come from registers or are decoded from the state register only; no input-to-output combinational path.
- Requesters deassert `req` on `gnt`. A `req` still high when the arbiter returns to IDLE is a new request.
- `req` and operand changes outside IDLE are ignored.
- `dp_valid` outside WAIT is ignored and not counted.
- Results pass through unmodified. The arbiter performs no arithmetic except the `ptr`/counter increments, both of which wrap modulo their range.

## Timing
- Reset values: state IDLE, `ptr` 0, counter 0; `gnt`, `rsp_valid`, `rsp_q`, `rsp_rmd`, `rsp_err`, `busy`, `dp_start`, `dp_a`..`dp_d` all 0.
- Reset asserted mid-operation returns everything to reset values immediately, without waiting for a clock edge. No response is issued for the aborted operation.
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: ISSUE (`gnt`, `dp_start`).
- Cycle 2: `dp_valid` from the registered datapath, captured in WAIT.
- Cycle 3: RESP with `rsp_valid`.
- Nominal latency is 3 cycles from request sample to response. Back-to-back throughput is one operation per 4 cycles.
- Timeout case: `rsp_valid` with `rsp_err` arrives TMO+2 cycles after the request sample.
- Simultaneous requests: exactly one grant per operation. The others wait and are served in round-robin order, so no requester waits more than N-1 operations.

## Test plan
- **Single request:** requester 0 sends a=10, b=4, c=2, d=1.
  - Required: `gnt[0]` at cycle 1, `dp_start` at cycle 1.
  - Required: `rsp_valid[0]` at cycle 3 with `rsp_q`=19, `rsp_rmd`=0, `rsp_err`=0.
- **Odd and negative results:** a=5, b=2, c=0, d=0 -> q=1, rmd=1. a=0, b=1, c=0, d=0 -> q=-1, rmd=1.
- **Round-robin fairness:** with N=4, all `req` held high continuously.
  - Required: grant order 0, 1, 2, 3, 0, with one operation every 4 cycles.
  - Required: each `rsp_valid` bit is one-hot and matches the preceding `gnt`.
- **Timeout:** the bench suppresses `dp_valid` with TMO=8.
  - Required: `rsp_valid[id]` with `rsp_err`=1 and `rsp_q`=0 at cycle 10.
  - Required: the next request is served normally afterwards.
- **Reset mid-operation:** assert `reset` during WAIT.
  - Required: `busy`, `dp_start` and all outputs are 0 immediately, with no `rsp_valid`.
  - Required: after release, the next request is granted with `ptr`=0 priority.
- **Spurious dp_valid:** pulse `dp_valid` while in IDLE and during RESP.
  - Required: no response, no state change, and the next result is still correct.
